printer_unit: RTL

Behavioural printer stage directly downstream of the printer output controller. Consumes the controller's `print_data`/`pulse_request` strobe, answers with `print_ready`, and models a print head busy for a fixed number of cycles per character. Printed bytes are queued in a small FIFO for a host/bench drain port. Characters and newline events are counted; overrun strobes are optionally counted.

---
 rtl/printer_pkg.sv | 14 +
 rtl/printer_fifo.sv | 52 +++++
 rtl/printer_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/printer_pkg.sv
// Shared types and defaults for the printer stage and its output FIFO.
// Defaults: 4 busy cycles per character and an 8-entry FIFO.
package printer_pkg;

  typedef enum logic {
    PRN_READY = 1'b0,
    PRN_BUSY  = 1'b1
  } prn_state_t;

  localparam logic [7:0] PRN_NEWLINE         = 8'h0A;
  localparam int         PRN_BUSY_CYCLES_DEF = 4;
  localparam int         PRN_DEPTH_DEF       = 8;

endpackage

// File: rtl/printer_fifo.sv
// Synchronous byte FIFO. Output data is combinational from the head entry.
// Push is ignored when full and pop is ignored when empty. Reads 0x00 when empty.
module printer_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/printer_unit.sv
// Print-head model: accepts one byte per strobe rising edge, stays busy BUSY_CYCLES, queues bytes.
// Optional PRINTER_OVERRUN_CNT_EN adds a saturating count of rejected strobes.
module printer_unit
  import printer_pkg::*;
#(
  parameter int BUSY_CYCLES = PRN_BUSY_CYCLES_DEF,
  parameter int DEPTH       = PRN_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  print_data,
  input  logic        pulse_request,
  output logic        print_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [15:0] char_count,
  output logic [15:0] line_count,
  output logic [7:0]  overrun_cnt
);

  prn_state_t state;
  logic [7:0] busy_cnt;
  logic       pulse_d;
  logic       rise;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic [$clog2(DEPTH):0] unused_fifo_count;

  assign rise        = pulse_request & ~pulse_d;
  // Pre-pop fullness: a same-cycle pop never makes room for this push.
  assign print_ready = (state == PRN_READY) & ~fifo_full;
  assign accept      = rise & print_ready;
  assign out_valid   = ~fifo_empty;

  printer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (print_data),
    .pop       (out_valid & out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // pulse_d resets high so a strobe held through reset release is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PRN_READY;
      busy_cnt   <= '0;
      pulse_d    <= 1'b1;
      char_count <= '0;
      line_count <= '0;
    end else begin
      pulse_d <= pulse_request;
      case (state)
        PRN_READY: begin
          if (accept) begin
            busy_cnt <= 8'(BUSY_CYCLES - 1);
            state    <= PRN_BUSY;
          end
        end
        PRN_BUSY: begin
          if (busy_cnt == '0) state    <= PRN_READY;
          else                busy_cnt <= busy_cnt - 1'b1;
        end
        default: state <= PRN_READY;
      endcase
      if (accept) begin
        char_count <= char_count + 1'b1;
        if (print_data == PRN_NEWLINE) line_count <= line_count + 1'b1;
      end
    end
  end

`ifdef PRINTER_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= '0;
    end else if (rise && !print_ready && overrun_q != 8'hFF) begin
      overrun_q <= overrun_q + 1'b1;
    end
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 8'h00;
`endif

endmodule
